// File: rtl/axis_bram_adapter_v1_0_sched.sv
// Round-robin transfer scheduler in front of the AXIS/BRAM adapter: grants one of two
// requesters, sequences the adapter reload, gates the stream handshakes and counts words/rows.
module axis_bram_adapter_v1_0_sched #(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [1:0]                      req,
  input  logic [1:0]                      req_rw,
  input  logic [2*BRAM_ADDR_LENGTH-1:0]   req_start,
  input  logic [2*BRAM_ADDR_LENGTH-1:0]   req_bound,
  output logic [1:0]                      ack,
  output logic [1:0]                      done,
  output logic                            busy,
  output logic                            rw,
  output logic                            addr_reload,
  output logic [BRAM_ADDR_LENGTH-1:0]     bram_start_index,
  output logic [BRAM_ADDR_LENGTH-1:0]     bram_bound_index,
  input  logic                            stream_in_valid,
  input  logic                            stream_out_accep,
  output logic                            stream_in_en,
  output logic                            stream_out_en
);

  localparam int A = BRAM_ADDR_LENGTH;
  localparam logic [5:0] WORD_LAST = 6'(BRAM_WIDTH_IN_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           rw_q, rw_d;
  logic           addr_reload_q, addr_reload_d;
  logic [A-1:0]   start_q, start_d;
  logic [A-1:0]   bound_q, bound_d;
  logic [A-1:0]   row_q, row_d;
  logic [5:0]     word_q, word_d;
  logic [1:0]     done_q, done_d;
  logic           last_grant_q, last_grant_d;

  logic           grant_s;
  logic [1:0]     ack_s;
  logic           run_s;
  logic           beat_s;

  // Round-robin pick; on contention the requester not served last wins.
  always_comb begin
    if (req == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ack is presented in the IDLE cycle that latches the command.
  always_comb begin
    if ((state_q == S_IDLE) && rstn && (req != 2'b00)) begin
      ack_s = grant_s ? 2'b10 : 2'b01;
    end else begin
      ack_s = 2'b00;
    end
  end

  assign run_s  = (state_q == S_RUN);
  assign beat_s = run_s & (rw_q ? stream_in_valid : stream_out_accep);

  // Next-state and counter logic.
  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    addr_reload_d = 1'b0;
    start_d       = start_q;
    bound_d       = bound_q;
    row_d         = row_q;
    word_d        = word_q;
    done_d        = 2'b00;
    last_grant_d  = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          rw_d          = req_rw[grant_s];
          start_d       = grant_s ? req_start[2*A-1:A] : req_start[A-1:0];
          bound_d       = grant_s ? req_bound[2*A-1:A] : req_bound[A-1:0];
          last_grant_d  = grant_s;
          addr_reload_d = 1'b1;
          state_d       = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        word_d  = 6'd0;
        row_d   = start_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!beat_s) begin
          state_d = S_RUN;
        end else if (word_q != WORD_LAST) begin
          word_d = word_q + 6'd1;
        end else if (row_q != bound_q) begin
          // Row index wraps naturally at 2^A.
          word_d = 6'd0;
          row_d  = row_q + A'(1'b1);
        end else begin
          state_d = S_DONE;
          done_d  = last_grant_q ? 2'b10 : 2'b01;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      rw_q          <= 1'b0;
      addr_reload_q <= 1'b0;
      start_q       <= '0;
      bound_q       <= '0;
      row_q         <= '0;
      word_q        <= 6'd0;
      done_q        <= 2'b00;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      addr_reload_q <= addr_reload_d;
      start_q       <= start_d;
      bound_q       <= bound_d;
      row_q         <= row_d;
      word_q        <= word_d;
      done_q        <= done_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign ack              = ack_s;
  assign done             = done_q;
  assign busy             = (state_q != S_IDLE);
  assign rw               = rw_q;
  assign addr_reload      = addr_reload_q;
  assign bram_start_index = start_q;
  assign bram_bound_index = bound_q;
  assign stream_in_en     = run_s & rw_q;
  assign stream_out_en    = run_s & ~rw_q;

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// Scoreboard bench for the transfer scheduler: directed commands push expected records,
// a negedge monitor compares ack, reload, beat counts and done against them.
module tb_axis_bram_adapter_v1_0_sched;

  localparam int A = 12;

  typedef struct {
    logic [1:0]   grant;
    logic         rw;
    logic [A-1:0] start;
    logic [A-1:0] bound;
    int           beats;
    int           gates;
  } exp_t;

  logic           clk;
  logic           rstn;
  logic [1:0]     req;
  logic [1:0]     req_rw;
  logic [2*A-1:0] req_start;
  logic [2*A-1:0] req_bound;
  logic [1:0]     ack;
  logic [1:0]     done;
  logic           busy;
  logic           rw;
  logic           addr_reload;
  logic [A-1:0]   bram_start_index;
  logic [A-1:0]   bram_bound_index;
  logic           stream_in_valid;
  logic           stream_out_accep;
  logic           stream_in_en;
  logic           stream_out_en;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   mon_beats = 0;
  int   mon_gates = 0;
  int   mon_reloads = 0;
  int   ack_cyc = 0;
  int   beat_cyc = 0;
  bit   busy_pend = 1'b0;
  bit   toggle_mode = 1'b0;
  bit   tog = 1'b1;

  axis_bram_adapter_v1_0_sched #(
    .BRAM_ADDR_LENGTH  (12),
    .BRAM_WIDTH_IN_WORD(36)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req             (req),
    .req_rw          (req_rw),
    .req_start       (req_start),
    .req_bound       (req_bound),
    .ack             (ack),
    .done            (done),
    .busy            (busy),
    .rw              (rw),
    .addr_reload     (addr_reload),
    .bram_start_index(bram_start_index),
    .bram_bound_index(bram_bound_index),
    .stream_in_valid (stream_in_valid),
    .stream_out_accep(stream_out_accep),
    .stream_in_en    (stream_in_en),
    .stream_out_en   (stream_out_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Stream sources: constant 1, or tready toggling 1,0,1,... over RUN cycles.
  initial begin
    stream_in_valid  = 1'b1;
    stream_out_accep = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode && stream_out_en) begin
        stream_out_accep = tog;
        tog = ~tog;
      end else begin
        stream_out_accep = 1'b1;
        tog = 1'b1;
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        mon_beats   = 0;
        mon_gates   = 0;
        mon_reloads = 0;
        busy_pend   = 1'b0;
      end else begin
        if (busy_pend) begin
          chk("busy_after_done", {31'd0, busy}, 32'd0);
          busy_pend = 1'b0;
        end
        if (ack != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", {30'd0, ack}, 32'd0);
          end else begin
            chk("ack_grant", {30'd0, ack}, {30'd0, exp_q[0].grant});
            ack_cyc     = cyc;
            mon_beats   = 0;
            mon_gates   = 0;
            mon_reloads = 0;
          end
        end
        if (addr_reload) begin
          mon_reloads++;
          if (exp_q.size() != 0) begin
            chk("reload_timing", cyc, ack_cyc + 1);
            chk("start_index", {20'd0, bram_start_index}, {20'd0, exp_q[0].start});
            chk("bound_index", {20'd0, bram_bound_index}, {20'd0, exp_q[0].bound});
            chk("rw_dir", {31'd0, rw}, {31'd0, exp_q[0].rw});
          end
        end
        if (stream_in_en || stream_out_en) begin
          mon_gates++;
          if ((stream_in_en && stream_in_valid) || (stream_out_en && stream_out_accep)) begin
            mon_beats++;
            beat_cyc = cyc;
          end
        end
        if (done != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", {30'd0, done}, 32'd0);
          end else begin
            chk("done_grant", {30'd0, done}, {30'd0, exp_q[0].grant});
            chk("beat_count", mon_beats, exp_q[0].beats);
            chk("gate_cycles", mon_gates, exp_q[0].gates);
            chk("reload_pulses", mon_reloads, 1);
            chk("done_timing", cyc, beat_cyc + 1);
            void'(exp_q.pop_front());
            busy_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_ack();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (ack != 2'b00) break;
    end
    if (n == 1000) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int idx);
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done[idx]) break;
    end
    if (n == 1000) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    req = 2'b00;
  endtask

  task automatic push(input logic [1:0] g, input logic d, input logic [A-1:0] s,
                      input logic [A-1:0] b, input int beats, input int gates);
    exp_t e;
    e.grant = g; e.rw = d; e.start = s; e.bound = b; e.beats = beats; e.gates = gates;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {4'd0, ack, done, busy, rw, addr_reload, stream_in_en, stream_out_en,
         bram_start_index, bram_bound_index}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rstn      = 1'b0;
    req       = 2'b00;
    req_rw    = 2'b00;
    req_start = '0;
    req_bound = '0;
    do_reset();

    // Write from requester 0, rows 0x010..0x011: 72 beats.
    req_rw = 2'b01; req_start = {12'h000, 12'h010}; req_bound = {12'h000, 12'h011};
    push(2'b01, 1'b1, 12'h010, 12'h011, 72, 72);
    req = 2'b01;
    wait_ack();
    drop_req();
    wait_done(0);

    // Read from requester 1, single row, tready toggling: 36 beats over 71 RUN cycles.
    repeat (2) @(posedge clk);
    #1;
    toggle_mode = 1'b1;
    req_rw = 2'b00; req_start = {12'h005, 12'h000}; req_bound = {12'h005, 12'h000};
    push(2'b10, 1'b0, 12'h005, 12'h005, 36, 71);
    req = 2'b10;
    wait_ack();
    drop_req();
    wait_done(1);
    toggle_mode = 1'b0;

    // Both requesters held after reset: grants 0, 1, 0.
    do_reset();
    req_rw = 2'b01; req_start = {12'h030, 12'h020}; req_bound = {12'h030, 12'h020};
    push(2'b01, 1'b1, 12'h020, 12'h020, 36, 36);
    push(2'b10, 1'b0, 12'h030, 12'h030, 36, 36);
    push(2'b01, 1'b1, 12'h020, 12'h020, 36, 36);
    req = 2'b11;
    wait_ack();
    wait_ack();
    wait_ack();
    drop_req();
    wait_done(0);

    // Row wrap 0xFFF -> 0x000, write from requester 1.
    repeat (2) @(posedge clk);
    #1;
    req_rw = 2'b10; req_start = {12'hFFF, 12'h000}; req_bound = {12'h000, 12'h000};
    push(2'b10, 1'b1, 12'hFFF, 12'h000, 72, 72);
    req = 2'b10;
    wait_ack();
    drop_req();
    wait_done(1);

    // Reset at beat 20 of a 36-beat read: no done, then a fresh command.
    repeat (2) @(posedge clk);
    #1;
    req_rw = 2'b00; req_start = {12'h000, 12'h007}; req_bound = {12'h000, 12'h007};
    push(2'b01, 1'b0, 12'h007, 12'h007, 36, 36);
    req = 2'b01;
    wait_ack();
    drop_req();
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (mon_beats >= 20) break;
    end
    chk("abort_reached_beat20", mon_beats, 32'd20);
    rstn = 1'b0;
    #1;
    chk("abort_async_clear", {27'd0, stream_in_en, stream_out_en, busy, done}, 32'd0);
    void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", {29'd0, done, busy}, 32'd0);
    @(posedge clk);
    #1;
    req_rw = 2'b00; req_start = {12'h0AB, 12'h000}; req_bound = {12'h0AB, 12'h000};
    push(2'b10, 1'b0, 12'h0AB, 12'h0AB, 36, 36);
    req = 2'b10;
    wait_ack();
    drop_req();
    wait_done(1);

    // Back-to-back: requester 0 re-requests in its done cycle.
    repeat (2) @(posedge clk);
    #1;
    req_rw = 2'b01; req_start = {12'h000, 12'h100}; req_bound = {12'h000, 12'h100};
    push(2'b01, 1'b1, 12'h100, 12'h100, 36, 36);
    req = 2'b01;
    wait_ack();
    drop_req();
    wait_done(0);
    #1;
    req_start = {12'h000, 12'h200}; req_bound = {12'h000, 12'h200};
    push(2'b01, 1'b1, 12'h200, 12'h200, 36, 36);
    req = 2'b01;
    @(negedge clk);
    chk("b2b_ack_gap", {30'd0, ack}, 32'd1);
    drop_req();
    wait_done(0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
